// File: rtl/pipeline_sequencer_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding and
// default widths/depths used by the sequencer and its counters.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipeline_sequencer_sat.sv
// Saturating event counter with synchronous clear; clear wins over count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up to all-ones and stick there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline sequencer: stage enables/flushes from hazards, plus a
// halt sequence that drains EX/MEM/WB before stopping until a go pulse.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_busy,
  input  logic             branch_taken,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             go,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  seq_state_e    r_state, w_state_nxt;
  logic [DW-1:0] r_drain_cnt, w_drain_nxt, w_drain_inc;
  logic          w_redirect, w_bubble, w_accept;

  // Hazard priority in RUN: mem_busy > branch_taken > stall > halt_req.
  assign w_redirect = (r_state == ST_RUN) && !mem_busy && branch_taken;
  assign w_bubble   = (r_state == ST_RUN) && !mem_busy && !branch_taken && stall;
  assign w_accept   = (r_state == ST_RUN) && !mem_busy && !branch_taken && !stall && halt_req;
  assign w_drain_inc = r_drain_cnt + {{(DW-1){1'b0}}, 1'b1};

  // State and drain-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= {DW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Next-state logic; a frozen DRAIN cycle makes no drain progress.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = {DW{1'b0}};
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (mem_busy) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_drain_inc >= DRAIN_LAST) begin
          w_state_nxt = ST_HALT;
          w_drain_nxt = w_drain_inc;
        end else begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = w_drain_inc;
        end
      end
      ST_HALT: begin
        if (go) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_drain_nxt = {DW{1'b0}};
      end
    endcase
  end

  // Zero-latency stage enables and flushes.
  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    {ifid_flush, idex_flush}                      = 2'b00;
    case (r_state)
      ST_RUN: begin
        if (mem_busy) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else if (branch_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          {ifid_flush, idex_flush}                      = 2'b11;
        end else if (stall) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00111;
          {ifid_flush, idex_flush}                      = 2'b01;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
      ST_DRAIN: begin
        if (mem_busy) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00111;
          {ifid_flush, idex_flush}                      = 2'b01;
        end
      end
      ST_HALT: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end
      default: begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end
    endcase
  end

  assign halted = (r_state == ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_bubble),
    .i_clr (clr_cnt),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_redirect),
    .i_clr (clr_cnt),
    .o_cnt (flush_cnt)
  );

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, event-counter width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, cycles to retire the EX/MEM/WB occupants before halting.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_busy  input  1  data memory not ready; freeze the whole pipeline.
REQ-006 SHALL have port branch_taken  input  1  EX-stage branch/jump redirect.
REQ-007 SHALL have port stall  input  1  load-use hazard from the conflict-judge logic.
REQ-008 SHALL have port halt_req  input  1  ID holds a halting syscall (funct 0x0c, $v0 = 10).
REQ-009 SHALL have port go  input  1  resume pulse from the debug/board side.
REQ-010 SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-011 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage register enables.
REQ-012 SHALL have outputs ifid_flush, idex_flush  output  1 each  insert bubble into IF/ID or ID/EX.
REQ-013 SHALL have port halted  output  1  pipeline stopped in HALT.
REQ-014 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  load-use stall cycles and branch flushes.

Function
REQ-015 SHALL implement states RUN, DRAIN, HALT; the state, drain counter and event counters are registered; the enables and flushes are combinational from the current state and inputs (zero latency).
REQ-016 SHALL apply this priority in every state: mem_busy > branch_taken > stall > halt_req.
REQ-017 SHALL, when mem_busy=1 in RUN or DRAIN, drive all enables to 0 and all flushes to 0; the state, drain counter and event counters SHALL hold.
REQ-018 SHALL, on branch_taken in RUN, drive pc_en=1, all enables=1, ifid_flush=1 and idex_flush=1; a simultaneous halt_req or stall SHALL be discarded.
REQ-019 SHALL, on stall in RUN, drive pc_en=0, ifid_en=0, idex_flush=1 and exmem_en=memwb_en=1.
REQ-020 SHALL, on halt_req alone in RUN, behave as a normal cycle (all enables=1, no flush) and transition to DRAIN with the drain counter=0.
REQ-021 SHALL, in an unfrozen DRAIN cycle, drive pc_en=0, ifid_en=0 and idex_flush=1 with exmem_en=memwb_en=1, and increment the drain counter.
REQ-022 SHALL transition DRAIN->HALT in the cycle in which the drain counter reaches DRAIN_CYCLES-1 unfrozen.
REQ-023 SHALL ignore branch_taken, stall and halt_req in DRAIN and in HALT.
REQ-024 SHALL, in HALT, drive all enables=0, all flushes=0 and halted=1.
REQ-025 SHALL transition HALT->RUN on go=1; go SHALL be ignored in RUN and DRAIN.
REQ-026 SHALL increment stall_cnt on each cycle in which REQ-019 applies.
REQ-027 SHALL increment flush_cnt on each cycle in which REQ-018 applies.
REQ-028 SHALL make both counters saturate at all-ones, with no wrap-around.
REQ-029 SHALL give clr_cnt priority over any increment in the same cycle; the resulting counter value is 0.

Reset
REQ-030 SHALL, on rst_n low, asynchronously enter RUN with drain counter=0, stall_cnt=0, flush_cnt=0 and halted=0; the enables then follow REQ-015 to REQ-019.
REQ-031 SHALL abandon DRAIN or HALT on reset asserted mid-operation, with no pending halt retained.

Structure
REQ-032 SHALL take the state encoding, the DRAIN_CYCLES default and the CNT_W default from a shared pipeline control package.
REQ-033 SHALL instantiate a sub-module sat_counter (enable, clear, saturate) twice, once for stall_cnt and once for flush_cnt.

Verification
REQ-034 SHALL cover: stall=1 for 2 cycles in RUN -> pc_en=0, idex_flush=1 in both cycles; stall_cnt=2.
REQ-035 SHALL cover: branch_taken=1, stall=1 and halt_req=1 together -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged, state stays RUN.
REQ-036 SHALL cover: halt_req pulse with mem_busy=1 on the 2nd DRAIN cycle -> halted=1 exactly 4 cycles after acceptance; go pulse -> RUN the next cycle, halted=0.
REQ-037 SHALL cover: CNT_W=4 with 20 stall cycles -> stall_cnt holds at 15; clr_cnt together with stall -> stall_cnt=0.
REQ-038 SHALL cover: rst_n low during DRAIN -> immediate RUN and counters 0; no halt after release.
REQ-039 SHALL cover: go=1 during RUN and during DRAIN -> no state effect.
